fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/control logic.
- Owns the PC register and issues one-at-a-time requests to instruction memory.
- Holds the returned word on Instr with a valid/ready handshake.
- Computes the next PC from the redirect controls (PCsrc, reg_jump) that decode returns for the instruction it consumes.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of decode/control.
//   Owns the PC, issues one-at-a-time requests to instruction memory, holds the
//   returned word on Instr with a valid/ready handshake and computes the next
//   PC from the redirect controls decode returns for the consumed instruction.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req, imem_addr      single-cycle fetch request strobe and address
//   imem_rvalid, imem_rdata  memory response (1+ cycles after the request)
//   Instr, pc_o, pc_plus4    held instruction, its address, address+4
//   instr_valid, instr_ready handshake towards decode
//   PCsrc, reg_jump, ImmOp, jalr_target  redirect controls for consumed instr
//   fetch_fault              sticky misaligned-next-PC flag, fetching halted
//   fetch_count              number of instructions consumed by decode
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PCsrc,
   input  logic        reg_jump,
   input  logic [31:0] ImmOp,
   input  logic [31:0] jalr_target,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StFull, StFault} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] count_q, count_d;
   logic [31:0] next_pc;
   logic        consume;

   // valid_q is only ever set while in StFull.
   assign consume = valid_q & instr_ready;

   always_comb begin
      if (!PCsrc) begin
         next_pc = pc_q + 32'd4;
      end else if (reg_jump) begin
         next_pc = {jalr_target[31:1], 1'b0};
      end else begin
         next_pc = pc_q + ImmOp;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      count_d    = count_q;
      unique case (state_q)
         StIdle: state_d = StReq;
         StReq:  state_d = StWait;
         StWait: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               pc_d    = fetch_pc_q;
               valid_d = 1'b1;
               state_d = StFull;
            end
         end
         StFull: begin
            if (consume) begin
               count_d    = count_q + 32'd1;
               fetch_pc_d = next_pc;
               valid_d    = 1'b0;
               instr_d    = NOP_INSTR;
               if (next_pc[1:0] == 2'b00) begin
                  state_d = StReq;
               end else begin
                  fault_d = 1'b1;
                  state_d = StFault;
               end
            end
         end
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         count_q    <= count_d;
      end
   end

   assign imem_req    = (state_q == StReq);
   assign imem_addr   = fetch_pc_q;
   assign Instr       = instr_q;
   assign pc_o        = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] Instr;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        PCsrc = 1'b0;
   logic        reg_jump = 1'b0;
   logic [31:0] ImmOp = 32'd0;
   logic [31:0] jalr_target = 32'd0;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .Instr       (Instr),
      .pc_o        (pc_o),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .PCsrc       (PCsrc),
      .reg_jump    (reg_jump),
      .ImmOp       (ImmOp),
      .jalr_target (jalr_target),
      .fetch_fault (fetch_fault),
      .fetch_count (fetch_count)
   );

   // Memory model: responds 'lat' cycles after a request; updates 1 unit after posedge.
   int          lat = 1;
   bit          noise = 1'b0;
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [31:0] req_addr = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      #1;
      imem_rvalid = 1'b0;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(req_addr);
               pend        = 1'b0;
            end
         end
         if (imem_req) begin
            pend     = 1'b1;
            cnt      = lat;
            req_addr = imem_addr;
         end
         if (noise && !imem_rvalid && ($urandom_range(1, 0) == 1)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      instr_ready = 1'b0;
      PCsrc = 1'b0;
      reg_jump = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (at negedges) for instr_valid; a timeout counts as a failed comparison.
   task automatic wait_valid(input string name);
      int n = 0;
      while (!instr_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_valid) chk({name, " valid timeout"}, 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic        pcsrc;
      logic        rj;
      logic [31:0] imm;
      logic [31:0] jt;
      logic [31:0] next;
      logic        fault;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004, 1'b0};
      vecs[1] = '{32'h0000_0004, 1'b0, 1'b1, 32'h0,         32'h0000_0777, 32'h0000_0008, 1'b0};
      vecs[2] = '{32'h0000_0008, 1'b1, 1'b0, 32'h0000_0038, 32'h0,         32'h0000_0040, 1'b0};
      vecs[3] = '{32'h0000_0040, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0000_0030, 1'b0};
      vecs[4] = '{32'h0000_0030, 1'b1, 1'b1, 32'h0,         32'h0000_0041, 32'h0000_0040, 1'b0};
      vecs[5] = '{32'h0000_0040, 1'b1, 1'b1, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
      vecs[6] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b0};
      vecs[7] = '{32'h0000_0000, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0040, 1'b0};
      vecs[8] = '{32'h0000_0040, 1'b1, 1'b1, 32'h0,         32'h0000_0123, 32'h0000_0122, 1'b1};

      // Reset state
      @(negedge clk);
      chk("rst valid", {31'd0, instr_valid}, 32'd0);
      chk("rst req", {31'd0, imem_req}, 32'd0);
      chk("rst addr", imem_addr, 32'h0);
      chk("rst instr", Instr, NOP);
      chk("rst pc", pc_o, 32'h0);
      chk("rst pc4", pc_plus4, 32'h4);
      chk("rst fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst count", fetch_count, 32'd0);

      // Table-driven redirect sequence
      lat = 1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         wait_valid($sformatf("v%0d", i));
         chk($sformatf("v%0d pc", i), pc_o, vecs[i].pc);
         chk($sformatf("v%0d instr", i), Instr, mem_word(vecs[i].pc));
         chk($sformatf("v%0d pc4", i), pc_plus4, vecs[i].pc + 32'd4);
         instr_ready = 1'b1;
         PCsrc       = vecs[i].pcsrc;
         reg_jump    = vecs[i].rj;
         ImmOp       = vecs[i].imm;
         jalr_target = vecs[i].jt;
         @(negedge clk);
         instr_ready = 1'b0;
         PCsrc       = 1'b0;
         reg_jump    = 1'b0;
         chk($sformatf("v%0d req", i), {31'd0, imem_req}, {31'd0, ~vecs[i].fault});
         chk($sformatf("v%0d addr", i), imem_addr, vecs[i].next);
         chk($sformatf("v%0d fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].fault});
         chk($sformatf("v%0d count", i), fetch_count, i + 1);
         if (vecs[i].fault) begin
            chk("jalr flt valid", {31'd0, instr_valid}, 32'd0);
            chk("jalr flt instr", Instr, NOP);
         end
      end

      // Throughput: requests every 3rd cycle at latency 1, ready held high
      do_reset();
      instr_ready = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         chk($sformatf("tp req c%0d", k), {31'd0, imem_req}, {31'd0, (k % 3) == 1});
         if (k % 3 == 1) chk($sformatf("tp addr c%0d", k), imem_addr, 32'd4 * ((k - 1) / 3));
         if (k % 3 == 0 && k > 0) chk($sformatf("tp pc c%0d", k), pc_o, 32'd4 * (k / 3 - 1));
         @(negedge clk);
      end
      chk("tp count", fetch_count, 32'd3);
      instr_ready = 1'b0;

      // Stall for 5 cycles in FULL with rvalid noise
      wait_valid("stall");
      noise = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall pc c%0d", k), pc_o, 32'hC);
         chk($sformatf("stall instr c%0d", k), Instr, mem_word(32'hC));
         chk($sformatf("stall req c%0d", k), {31'd0, imem_req}, 32'd0);
         chk($sformatf("stall count c%0d", k), fetch_count, 32'd3);
      end
      noise = 1'b0;
      @(negedge clk);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      chk("stall next req", {31'd0, imem_req}, 32'd1);
      chk("stall next addr", imem_addr, 32'h10);
      chk("stall count", fetch_count, 32'd4);

      // Misaligned branch target: pc 0x10 + 6
      do_reset();
      wait_valid("f0");
      PCsrc = 1'b1;
      ImmOp = 32'h10;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      wait_valid("f1");
      chk("flt pc", pc_o, 32'h10);
      ImmOp = 32'h6;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      PCsrc = 1'b0;
      chk("flt fault", {31'd0, fetch_fault}, 32'd1);
      chk("flt valid", {31'd0, instr_valid}, 32'd0);
      begin
         int reqs = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req) reqs++;
         end
         chk("flt no req", reqs, 32'd0);
      end
      chk("flt sticky", {31'd0, fetch_fault}, 32'd1);

      // Reset mid-WAIT at latency 4
      lat = 4;
      do_reset();
      @(negedge clk);
      chk("rw req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      begin
         int n = 0;
         int seen = 0;
         while (!instr_valid && n < 20) begin
            if (imem_req && seen == 0) begin
               chk("rw first addr", imem_addr, 32'h0);
               seen = 1;
            end
            chk($sformatf("rw count c%0d", n), fetch_count, 32'd0);
            @(negedge clk);
            n++;
         end
         chk("rw req seen", seen, 32'd1);
         chk("rw latency", n, 32'd6);
      end
      chk("rw valid", {31'd0, instr_valid}, 32'd1);
      chk("rw pc", pc_o, 32'h0);
      chk("rw count", fetch_count, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
